// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory RAM with hardware dump engine.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t;

  localparam int DMEM_WIDTH = 32;
  localparam int DMEM_DEPTH = 129600;

endpackage

// File: rtl/dmem_dump_fsm.sv
// Dump sequencer: walks a wrapped memory window and owns the RAM port while busy.
// One fetch cycle per word then holds valid until ready; >= 2 cycles per word.
module dmem_dump_fsm
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = $clog2(DEPTH + 1),
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              fetch_o,
  output logic [IDX_W-1:0]  ptr_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);

  dump_state_t       state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_sat;

  // A window longer than the memory would only repeat words, so clamp it.
  assign len_sat = (len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          ptr_d   = IDX_W'(base_i % ADDR_W'(DEPTH));
          cnt_d   = len_sat;
          state_d = (len_sat == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        addr_d  = ADDR_W'(ptr_q);
        state_d = SEND;
      end
      SEND: begin
        if (ready_i) begin
          cnt_d   = cnt_q - LEN_W'(1);
          ptr_d   = (ptr_q == IDX_W'(DEPTH - 1)) ? '0 : ptr_q + IDX_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign fetch_o = (state_q == FETCH);
  assign valid_o = (state_q == SEND);
  assign done_o  = (state_q == DONE);
  assign ptr_o   = ptr_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/dmem_ram_dump.sv
// Word-addressed data RAM with byte-enable writes, registered reads (latency 1) and a dump port.
// CPU accesses are dropped while a dump owns the single RAM port; dump words wait for dump_ready.
module dmem_ram_dump
  import dmem_pkg::*;
#(
  parameter int WIDTH  = DMEM_WIDTH,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [WIDTH/8-1:0] be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wd,
  output logic [WIDTH-1:0]  rd,
  output logic              rvalid,
  output logic              oob_err,
  output logic              busy,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [LEN_W-1:0]  dump_len,
  output logic [WIDTH-1:0]  dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_done
);

  localparam int NB    = WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);

  logic             fsm_busy;
  logic             fetch;
  logic [IDX_W-1:0] ptr;
  logic             in_range;
  logic             wr_en;
  logic             rd_en;
  logic [IDX_W-1:0] port_idx;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;
  logic             rvalid_q;
  logic             oob_q;
  logic [WIDTH-1:0] dump_data_q;

  dmem_dump_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .IDX_W  (IDX_W)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (dump_start),
    .base_i  (dump_base),
    .len_i   (dump_len),
    .ready_i (dump_ready),
    .busy_o  (fsm_busy),
    .fetch_o (fetch),
    .ptr_o   (ptr),
    .valid_o (dump_valid),
    .addr_o  (dump_addr),
    .done_o  (dump_done)
  );

  assign in_range = (addr < ADDR_W'(DEPTH));
  assign wr_en    = !fsm_busy && we && in_range;
  assign rd_en    = !fsm_busy && re;
  assign port_idx = fsm_busy ? ptr : addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[port_idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  // Nonblocking RAM update makes a same-cycle read return the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      rvalid_q    <= 1'b0;
      oob_q       <= 1'b0;
      dump_data_q <= '0;
    end else begin
      rvalid_q <= rd_en;
      oob_q    <= !fsm_busy && (we || re) && !in_range;
      if (rd_en) begin
        rd_q <= in_range ? mem[port_idx] : '0;
      end
      if (fetch) begin
        dump_data_q <= mem[port_idx];
      end
    end
  end

  assign rd        = rd_q;
  assign rvalid    = rvalid_q;
  assign oob_err   = oob_q;
  assign dump_data = dump_data_q;
  assign busy      = fsm_busy;

endmodule

// File: tb/tb_dmem_ram_dump.sv
// Scoreboard bench for dmem_ram_dump: directed CPU and dump traffic, monitor on the falling edge.
module tb_dmem_ram_dump;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 129600;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              we, re;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  rd;
  logic              rvalid, oob_err, busy;
  logic              dump_start;
  logic [ADDR_W-1:0] dump_base;
  logic [LEN_W-1:0]  dump_len;
  logic [WIDTH-1:0]  dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_valid, dump_ready, dump_done;

  dmem_ram_dump #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .be(be), .addr(addr), .wd(wd),
    .rd(rd), .rvalid(rvalid), .oob_err(oob_err), .busy(busy),
    .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic oob; } rd_exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } dmp_exp_t;

  rd_exp_t  rd_exp_q[$];
  dmp_exp_t dmp_exp_q[$];
  int woob_pend = 0;
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  logic        prev_v = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (rvalid) begin
        if (rd_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rvalid actual=1 required=0 rd=%h", rd);
        end else begin
          rd_exp_t e;
          e = rd_exp_q.pop_front();
          chk("rd_data", rd, e.data);
          chk("rd_oob", 32'(oob_err), 32'(e.oob));
        end
      end else if (oob_err) begin
        checks++;
        if (woob_pend == 0) begin
          failures++;
          $display("FAIL unexpected_oob actual=1 required=0");
        end else begin
          woob_pend--;
        end
      end
      if (prev_v && !prev_hs) begin
        chk("dump_valid_held", 32'(dump_valid), 32'd1);
        chk("dump_addr_stable", dump_addr, prev_addr);
        chk("dump_data_stable", dump_data, prev_data);
      end
      if (dump_valid && dump_ready) begin
        hs_cnt++;
        if (dmp_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_dump_word actual=%h@%0d required=none", dump_data, dump_addr);
        end else begin
          dmp_exp_t d;
          d = dmp_exp_q.pop_front();
          chk("dump_addr", dump_addr, d.addr);
          chk("dump_data", dump_data, d.data);
        end
      end
      if (dump_done) done_cnt++;
      prev_v    = dump_valid;
      prev_hs   = dump_valid && dump_ready;
      prev_addr = dump_addr;
      prev_data = dump_data;
    end
  end

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input bit oob);
    if (oob) woob_pend++;
    we = 1'b1; addr = a; wd = d; be = b;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp_d, input bit oob);
    rd_exp_q.push_back('{data: exp_d, oob: oob});
    re = 1'b1; addr = a;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic push_dump(input logic [31:0] a, input logic [31:0] d);
    dmp_exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic run_dump(input int base, input int len, input int stall_word, input int stall_cycles,
                          input bit poke, output int done_lat);
    int d0, h0, stalled;
    bit got_done, finished, busy_ok;
    d0 = done_cnt; h0 = hs_cnt; stalled = 0;
    got_done = 0; finished = 0; busy_ok = 1; done_lat = -1;
    dump_base = ADDR_W'(base); dump_len = LEN_W'(len);
    dump_ready = 1'b1; dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      if (got_done) begin
        finished = 1;
      end else if (dump_done) begin
        got_done = 1;
        done_lat = c + 1;
      end else if (!busy) begin
        busy_ok = 0;
      end
      if (dump_valid && (hs_cnt - h0) == stall_word && stalled < stall_cycles) begin
        dump_ready = 1'b0;
        stalled++;
      end else begin
        dump_ready = 1'b1;
      end
      if (poke && c == 0) begin
        we = 1'b1; re = 1'b1; addr = 32'd10; wd = 32'hFFFF_FFFF; be = 4'hF;
        dump_start = 1'b1; dump_base = 32'd20; dump_len = LEN_W'(1);
      end else begin
        we = 1'b0; re = 1'b0; dump_start = 1'b0;
      end
      if (!finished) begin
        @(posedge clk); #1;
      end
    end
    we = 1'b0; re = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
    chk("dump_done_seen", 32'(got_done), 32'd1);
    chk("dump_done_once", 32'(done_cnt - d0), 32'd1);
    chk("busy_throughout", 32'(busy_ok), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    int d0;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; be = '0; addr = '0; wd = '0;
    dump_start = 1'b0; dump_base = '0; dump_len = '0; dump_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", rd, 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_oob", 32'(oob_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_done", 32'(dump_done), 32'd0);
    chk("rst_dump_data", dump_data, 32'd0);
    chk("rst_dump_addr", dump_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    cpu_write(32'd5, 32'hDEADBEEF, 4'hF, 0);
    cpu_read(32'd5, 32'hDEADBEEF, 0);
    cpu_write(32'd5, 32'h11223344, 4'b0101, 0);
    cpu_read(32'd5, 32'hDE22BE44, 0);
    // Same-cycle read and write: old word comes back.
    rd_exp_q.push_back('{data: 32'hDE22BE44, oob: 1'b0});
    we = 1'b1; re = 1'b1; addr = 32'd5; wd = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    cpu_read(32'd5, 32'hCAFEF00D, 0);
    cpu_read(32'd129600, 32'd0, 1);
    cpu_write(32'd68928, 32'h12345678, 4'hF, 0);
    cpu_write(32'd200000, 32'h99999999, 4'hF, 1);
    cpu_read(32'd68928, 32'h12345678, 0);
    cpu_read(32'd5, 32'hCAFEF00D, 0);

    cpu_write(32'd10, 32'd1, 4'hF, 0);
    cpu_write(32'd11, 32'd2, 4'hF, 0);
    cpu_write(32'd12, 32'd3, 4'hF, 0);
    push_dump(32'd10, 32'd1); push_dump(32'd11, 32'd2); push_dump(32'd12, 32'd3);
    run_dump(10, 3, 1, 3, 0, lat);

    cpu_write(32'd129599, 32'hAAAA5555, 4'hF, 0);
    cpu_write(32'd0, 32'h0BADF00D, 4'hF, 0);
    push_dump(32'd129599, 32'hAAAA5555); push_dump(32'd0, 32'h0BADF00D);
    run_dump(129599, 2, -1, 0, 0, lat);

    run_dump(0, 0, -1, 0, 0, lat);
    chk("len0_done_latency_le2", 32'(lat >= 1 && lat <= 2), 32'd1);

    push_dump(32'd10, 32'd1); push_dump(32'd11, 32'd2); push_dump(32'd12, 32'd3);
    d0 = done_cnt;
    run_dump(10, 3, -1, 0, 1, lat);
    repeat (10) @(posedge clk);
    #1;
    chk("no_second_dump_busy", 32'(busy), 32'd0);
    chk("no_second_dump_done", 32'(done_cnt - d0), 32'd1);
    cpu_read(32'd10, 32'd1, 0);

    // Abort a dump with reset while a word is stalled in SEND.
    d0 = done_cnt;
    dump_base = 32'd10; dump_len = LEN_W'(3); dump_ready = 1'b0; dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (dump_valid) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("abort_reached_send", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_dump_valid", 32'(dump_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1; dump_ready = 1'b1;
    @(posedge clk); #1;
    cpu_read(32'd10, 32'd1, 0);
    cpu_read(32'd11, 32'd2, 0);
    cpu_read(32'd12, 32'd3, 0);
    cpu_read(32'd68928, 32'h12345678, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    chk("dump_queue_drained", 32'(dmp_exp_q.size()), 32'd0);
    chk("write_oob_seen", 32'(woob_pend), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ram_dump.md
Name: dmem_ram_dump

Overview:
- Parametrised data-memory RAM for the pipeline processor: word-addressed, byte-enable writes, registered read with a valid flag, and out-of-range detection.
- Adds a hardware dump engine that streams a memory window out over a valid/ready port, so image results are read back in hardware rather than through simulation-only file dumps.
- Sits on the processor's data-memory bus. The dump port connects to the output/readback logic.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 129600, number of words.
- ADDR_W, 32, address bus width; word address, not byte address.
- LEN_W, $clog2(DEPTH+1), width of the dump length field.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  CPU write strobe.
- re  in  1  CPU read strobe.
- be  in  WIDTH/8  byte enables for writes; bit i covers wd[8i+7:8i].
- addr  in  ADDR_W  CPU word address.
- wd  in  WIDTH  CPU write data.
- rd  out  WIDTH  CPU read data, registered.
- rvalid  out  1  rd updated this cycle.
- oob_err  out  1  one-cycle pulse: previous CPU access was out of range.
- busy  out  1  dump in progress; CPU accesses are ignored.
- dump_start  in  1  pulse that starts a dump.
- dump_base  in  ADDR_W  first word of the dump window.
- dump_len  in  LEN_W  number of words to dump.
- dump_data  out  WIDTH  streamed word.
- dump_addr  out  ADDR_W  address of dump_data.
- dump_valid  out  1  dump_data/dump_addr valid.
- dump_ready  in  1  sink accepts the current word.
- dump_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (rst_n low, async):
  - rd=0, rvalid=0, oob_err=0, busy=0, dump_valid=0, dump_done=0, dump_data=0, dump_addr=0.
  - FSM goes to IDLE. Memory contents are not cleared.
- CPU write, accepted only when busy=0:
  - If we=1 and addr<DEPTH, bytes with be[i]=1 are written at the clock edge; other bytes keep their value.
  - addr>=DEPTH: no write; oob_err=1 next cycle.
- CPU read, accepted only when busy=0:
  - re=1 gives rd=mem[addr] and rvalid=1 one cycle later (latency 1).
  - addr>=DEPTH: rd=0, rvalid=1, oob_err=1.
  - rd holds its value when no read occurs; rvalid is 0 otherwise.
- Read and write to the same address in one cycle are read-first: rd returns the old data.
- While busy=1, we and re are ignored: no write, rvalid=0, oob_err=0.
- Dump FSM states IDLE, FETCH, SEND, DONE:
  - IDLE: on dump_start, latch ptr=dump_base mod DEPTH and cnt=min(dump_len,DEPTH).
    - cnt=0 goes to DONE; otherwise goes to FETCH. busy=1 from the next cycle.
    - If dump_start coincides with a CPU write, the write completes first and the dump sees the new data.
  - FETCH: read mem[ptr]; next cycle go to SEND with dump_data=mem[ptr], dump_addr=ptr, dump_valid=1.
  - SEND: hold dump_data, dump_addr and dump_valid stable until dump_ready=1.
    - On the handshake: dump_valid=0 next cycle, ptr increments (DEPTH-1 wraps to 0), cnt decrements.
    - If cnt was 1, go to DONE; else go to FETCH.
    - Throughput is 1 word per 2 cycles minimum.
  - DONE: dump_done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
- dump_start while busy is ignored.
- dump_valid never drops without a handshake, except on reset.
- Reset asserted mid-dump aborts immediately: no dump_done, memory is retained.
- Memory is one inferred synchronous RAM array with a single shared port, muxed between CPU and dump FSM by busy.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] dump_state_t {IDLE, FETCH, SEND, DONE};
  - default constants DMEM_WIDTH=32 and DMEM_DEPTH=129600.
- Sub-module dmem_dump_fsm contains the state register, ptr/cnt counters, handshake and port-mux select.
- The top module holds the RAM array, byte-enable write logic and read register.

Test Plan:
- Reset, then write addr=5, wd=32'hDEADBEEF, be=4'hF; then read addr=5 -> next cycle rd=32'hDEADBEEF, rvalid=1, oob_err=0.
- Write addr=5, wd=32'h11223344, be=4'b0101 over DEADBEEF -> read returns 32'hDE22BE44.
- Read addr=129600 -> rd=0, rvalid=1, oob_err=1 for one cycle. Write addr=200000 -> no memory change, oob_err=1.
- Preload words 10..12 = 1,2,3; dump_base=10, dump_len=3, dump_ready stalled 3 cycles on word 2 -> sink sees (10,1),(11,2),(12,3) in order, data stable while stalled, dump_done pulses once, busy high throughout.
- dump_base=129599, dump_len=2 -> addresses 129599 then 0. dump_len=0 -> dump_done two cycles after dump_start, dump_valid never asserted.
- During busy, issue we to addr 10 and a second dump_start -> memory unchanged, no second dump. Pull rst_n low mid-SEND -> dump_valid=0 and busy=0 immediately, no dump_done, preloaded data intact on a later read.
